// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle, variable-amount shifter. It applies pass, LSL, LSR or ASR to
//   a WIDTH-bit operand by 0..(2**CNTW - 1) positions, moving one bit per clock.
//   A start/done handshake controls it. The controller stalls on busy while
//   the shift runs.
//
// Ports:
//   clk    in   rising-edge clock (only clock)
//   reset  in   synchronous, active-high reset (overrides start)
//   start  in   request, accepted only in IDLE or DONE
//   op     in   2  00 pass, 01 LSL (0-fill), 10 LSR (0-fill), 11 ASR (MSB-fill)
//   amt    in   CNTW  shift count
//   ain    in   WIDTH operand
//   out    out  WIDTH result register
//   busy   out  high while in SHIFT
//   done   out  one-cycle pulse in DONE, when out holds the final result
// -----------------------------------------------------------------------------
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNTW-1:0]  amt,
  input  logic [WIDTH-1:0] ain,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_LSR  = 2'b10;
  localparam logic [1:0] OP_ASR  = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [1:0]       op_q,    op_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;

  // One 1-bit step of the selected operation. Bits that move past either end
  // are discarded.
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0]       sel,
                                                  input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] res;
    case (sel)
      OP_LSL:  res = {val[WIDTH-2:0], 1'b0};
      OP_LSR:  res = {1'b0, val[WIDTH-1:1]};
      OP_ASR:  res = {val[WIDTH-1], val[WIDTH-1:1]};
      default: res = val;  // pass never reaches SHIFT
    endcase
    return res;
  endfunction

  // Next-state and datapath logic. By default every register holds its value.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Inputs are captured only on this edge. Later changes to them have
          // no effect.
          out_d = ain;
          op_d  = op;
          cnt_d = amt;
          if ((op == OP_PASS) || (amt == {CNTW{1'b0}})) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // start is ignored here. It is not queued.
        out_d = shift_step(op_q, out_q);
        cnt_d = cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNTW-1){1'b0}}, 1'b1}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset wins over any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= {WIDTH{1'b0}};
      op_q    <= 2'b00;
      cnt_q   <= {CNTW{1'b0}};
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status is decoded from registered state only, never from inputs.
  assign out  = out_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
//   Self-checking bench for seq_shifter. Table-driven single operations, plus
//   hand-written sequences for reset, ignored start, abort and back-to-back
//   issue. Inputs are driven #1 after the rising edge, and outputs are sampled
//   at the same point.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic [15:0] ain;
  logic [15:0] out;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  seq_shifter #(.WIDTH(16), .CNTW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .ain   (ain),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] ain;
    logic [15:0] exp_out;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request through the acceptance edge. On return the bench is in
  // cycle 1.
  task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
    start = 1'b1;
    op    = o;
    amt   = a;
    ain   = d;
    tick();
    start = 1'b0;
  endtask

  // Starting in cycle 1, walk forward until done, with a bounded budget.
  // Returns the cycle of done (0 if it never came), the output at that point,
  // and the number of cycles in which busy disagreed with its expected value.
  task automatic run_to_done(input int busy_cycles, output int lat,
                             output logic [15:0] res, output int busy_err);
    lat      = 0;
    res      = 16'h0000;
    busy_err = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy !== ((c <= busy_cycles) ? 1'b1 : 1'b0)) busy_err++;
      if (done === 1'b1) begin
        lat = c;
        res = out;
        break;
      end
      tick();
    end
  endtask

  vec_t        vecs[9];
  int          lat;
  int          berr;
  int          seen;
  logic [15:0] res;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{2'b01, 4'd4,  16'h00F1, 16'h0F10, 5};
    vecs[1] = '{2'b01, 4'd15, 16'h0001, 16'h8000, 16};
    vecs[2] = '{2'b11, 4'd15, 16'h8000, 16'hFFFF, 16};
    vecs[3] = '{2'b10, 4'd15, 16'h8000, 16'h0001, 16};
    vecs[4] = '{2'b11, 4'd3,  16'h7FF0, 16'h0FFE, 4};
    vecs[5] = '{2'b10, 4'd0,  16'h1234, 16'h1234, 1};
    vecs[6] = '{2'b00, 4'd9,  16'hBEEF, 16'hBEEF, 1};
    vecs[7] = '{2'b11, 4'd2,  16'h8001, 16'hE000, 3};
    vecs[8] = '{2'b01, 4'd1,  16'hC000, 16'h8000, 2};

    // Reset held for two cycles with start asserted: the request is ignored.
    reset = 1'b1;
    start = 1'b1;
    op    = 2'b01;
    amt   = 4'd4;
    ain   = 16'hFFFF;
    tick();
    tick();
    chk("reset_out",  32'(out),  32'h0000);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("post_reset_idle", 32'({busy, done}), 32'h0);
    chk("post_reset_out",  32'(out),          32'h0000);

    // Table of single operations, each started from IDLE.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].amt, vecs[i].ain);
      run_to_done((vecs[i].op == 2'b00) ? 0 : int'(vecs[i].amt), lat, res, berr);
      chk($sformatf("v%0d_latency", i), 32'(lat),  32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_out", i),     32'(res),  32'(vecs[i].exp_out));
      chk($sformatf("v%0d_busy", i),    32'(berr), 32'd0);
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
      chk($sformatf("v%0d_hold", i),       32'(out),  32'(vecs[i].exp_out));
    end

    // In IDLE, out holds its value over several cycles.
    for (int i = 0; i < 4; i++) tick();
    chk("idle_hold", 32'(out), 32'h8000);

    // A start pulse with 0xFFFF in cycle 2 of a 5-step LSL of 0x0003 is ignored.
    issue(2'b01, 4'd5, 16'h0003);
    tick();                        // now in cycle 2
    start = 1'b1;
    ain   = 16'hFFFF;
    op    = 2'b10;
    amt   = 4'd1;
    tick();                        // now in cycle 3
    start = 1'b0;
    run_to_done(5, lat, res, berr);
    // run_to_done counts from its entry cycle (3), so add 2.
    chk("ignore_latency", 32'(lat + 2), 32'd6);
    chk("ignore_out",     32'(res),     32'h0060);
    tick();

    // Reset in cycle 3 of a shift aborts it, and no done pulse appears.
    issue(2'b01, 4'd8, 16'h0001);
    tick();
    tick();                        // now in cycle 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", 32'({busy, done}), 32'h0);
    chk("abort_out",   32'(out),          32'h0000);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Back-to-back: LSR 2 of 0x0100, then LSL 1 of 0x4001 issued in the DONE cycle.
    issue(2'b10, 4'd2, 16'h0100);  // now in cycle 1
    chk("b2b_busy_c1", 32'(busy), 32'h1);
    tick();
    chk("b2b_busy_c2", 32'(busy), 32'h1);
    tick();                        // cycle 3
    chk("b2b_done_c3", 32'(done), 32'h1);
    chk("b2b_out1",    32'(out),  32'h0040);
    issue(2'b01, 4'd1, 16'h4001);  // now in cycle 4
    chk("b2b_done_c4", 32'(done), 32'h0);
    chk("b2b_busy_c4", 32'(busy), 32'h1);
    tick();                        // cycle 5
    chk("b2b_done_c5", 32'(done), 32'h1);
    chk("b2b_out2",    32'(out),  32'h8002);
    tick();
    chk("b2b_idle", 32'({busy, done}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
